// File: rtl/fwd_hazard_pkg.sv
// Shared types and helpers for the forwarding / hazard controller.
//   fwd_state_e : hazard FSM states (RUN, LU_STALL, FREEZE)
//   sel_w(n)    : width of an operand select able to encode n stages plus "register file"
//   ZERO_REG    : index of the hard-wired zero register, never forwarded
package fwd_hazard_pkg;

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      FREEZE
   } fwd_state_e;

   localparam int unsigned ZERO_REG = 0;

   function automatic int unsigned sel_w(input int unsigned n);
      return unsigned'($clog2(n + 1));
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_prio.sv
// fwd_prio_sel: nearest-stage priority matcher for one ALU operand.
// Ports:
//   srcReg  in  REG_AW             source register read by the EX instruction
//   stgWrEn in  NUM_STAGES         register-write enable per forwarding stage
//   stgRd   in  NUM_STAGES*REG_AW  destination per stage, packed [k*REG_AW +: REG_AW]
//   sel     out SEL_W              0 = register file, k+1 = stage k
module fwd_prio_sel
   import fwd_hazard_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned SEL_W      = sel_w(NUM_STAGES)
) (
   input  logic [REG_AW-1:0]            srcReg,
   input  logic [NUM_STAGES-1:0]        stgWrEn,
   input  logic [NUM_STAGES*REG_AW-1:0] stgRd,
   output logic [SEL_W-1:0]             sel
);

   // Walk from the farthest stage inwards so the nearest matching stage is written last and wins.
   always_comb begin
      sel = '0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         if (stgWrEn[k] && (stgRd[k*REG_AW +: REG_AW] == srcReg) &&
             (srcReg != REG_AW'(ZERO_REG))) begin
            sel = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding plus ID-stage load-use stall and memory-busy freeze.
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt                 source registers of the instruction in ID
//   ex_rs, ex_rt                 source registers of the instruction in EX
//   ex_mem_read, ex_rd           EX instruction is a load / its destination
//   stg_wr_en, stg_rd            per-stage write enable and destination of forwarding stages
//   mem_busy                     data memory not ready this cycle
//   fwd_a_sel, fwd_b_sel         ALU operand selects (0 = register file, k+1 = stage k)
//   pc_hold, ifid_hold           hold PC / IF-ID register
//   idex_flush                   insert bubble into ID/EX
//   pipe_freeze                  freeze ID/EX and all later pipeline registers
// Optional: define FWD_HAZARD_STATS_EN to add saturating stall_cnt, freeze_cnt, fwd_cnt outputs.
module fwd_hazard_unit
   import fwd_hazard_pkg::*;
#(
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned NUM_FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT       = 1,
   parameter int unsigned SEL_W          = sel_w(NUM_FWD_STAGES)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [REG_AW-1:0]                  id_rs,
   input  logic [REG_AW-1:0]                  id_rt,
   input  logic [REG_AW-1:0]                  ex_rs,
   input  logic [REG_AW-1:0]                  ex_rt,
   input  logic                               ex_mem_read,
   input  logic [REG_AW-1:0]                  ex_rd,
   input  logic [NUM_FWD_STAGES-1:0]          stg_wr_en,
   input  logic [NUM_FWD_STAGES*REG_AW-1:0]   stg_rd,
   input  logic                               mem_busy,
   output logic [SEL_W-1:0]                   fwd_a_sel,
   output logic [SEL_W-1:0]                   fwd_b_sel,
   output logic                               pc_hold,
   output logic                               ifid_hold,
   output logic                               idex_flush,
   output logic                               pipe_freeze
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [31:0]                        stall_cnt,
   output logic [31:0]                        freeze_cnt,
   output logic [31:0]                        fwd_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ---------------------------------------------------------------- forwarding
   fwd_prio_sel #(
      .REG_AW     (REG_AW),
      .NUM_STAGES (NUM_FWD_STAGES),
      .SEL_W      (SEL_W)
   ) u_selA (
      .srcReg  (ex_rs),
      .stgWrEn (stg_wr_en),
      .stgRd   (stg_rd),
      .sel     (fwd_a_sel)
   );

   fwd_prio_sel #(
      .REG_AW     (REG_AW),
      .NUM_STAGES (NUM_FWD_STAGES),
      .SEL_W      (SEL_W)
   ) u_selB (
      .srcReg  (ex_rt),
      .stgWrEn (stg_wr_en),
      .stgRd   (stg_rd),
      .sel     (fwd_b_sel)
   );

   // ---------------------------------------------------------------- hazard FSM
   fwd_state_e       stateQ, stateD;
   fwd_state_e       retQ, retD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             hz;
   logic             stallOut;
   logic             freezeOut;

   assign hz = ex_mem_read && (ex_rd != REG_AW'(ZERO_REG)) && ((ex_rd == id_rs) || (ex_rd == id_rt));

   always_comb begin
      stateD    = stateQ;
      retD      = retQ;
      cntD      = cntQ;
      stallOut  = 1'b0;
      freezeOut = 1'b0;
      if (mem_busy) begin
         // Freeze wins over any stall; the stall counter is parked untouched.
         freezeOut = 1'b1;
         if (stateQ != FREEZE) begin
            stateD = FREEZE;
            retD   = stateQ;
         end
      end else begin
         case (stateQ)
            RUN: begin
               if (hz) begin
                  stallOut = 1'b1;
                  if (LOAD_LAT > 1) begin
                     stateD = LU_STALL;
                     cntD   = CNT_INIT;
                  end
               end
            end
            LU_STALL: begin
               stallOut = 1'b1;
               cntD     = cntQ - CNT_ONE;
               if (cntQ == CNT_ONE) begin
                  stateD = RUN;
               end
            end
            // Memory released: resume where we left off; this cycle neither stalls nor freezes.
            FREEZE: begin
               stateD = retQ;
            end
            default: begin
               stateD = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= RUN;
         retQ   <= RUN;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         retQ   <= retD;
         cntQ   <= cntD;
      end
   end

   // Reset masks the control outputs immediately, independent of the clock.
   assign pc_hold     = !rst && (stallOut || freezeOut);
   assign ifid_hold   = !rst && (stallOut || freezeOut);
   assign idex_flush  = !rst && stallOut;
   assign pipe_freeze = !rst && freezeOut;

`ifdef FWD_HAZARD_STATS_EN
   // ---------------------------------------------------------------- statistics
   function automatic logic [31:0] satInc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   logic fwdActive;
   assign fwdActive = ((fwd_a_sel != '0) || (fwd_b_sel != '0)) && !pipe_freeze;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         freeze_cnt <= '0;
         fwd_cnt    <= '0;
      end else begin
         stall_cnt  <= satInc(stall_cnt, idex_flush);
         freeze_cnt <= satInc(freeze_cnt, pipe_freeze);
         fwd_cnt    <= satInc(fwd_cnt, fwdActive);
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two DUTs (LOAD_LAT = 1 and 3) share stimulus; expected responses are queued
// at drive time and compared by an independent monitor on the falling edge.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
   logic       ex_mem_read;
   logic [1:0] stg_wr_en;
   logic [9:0] stg_rd;
   logic       mem_busy;

   logic [1:0] aSel1, bSel1, aSel3, bSel3;
   logic       pc1, ifid1, fl1, fz1;
   logic       pc3, ifid3, fl3, fz3;
`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] sc1, fc1, wc1, sc3, fc3, wc3;
`endif

   always #5 clk = ~clk;

   fwd_hazard_unit #(.REG_AW(5), .NUM_FWD_STAGES(2), .LOAD_LAT(1)) u_dut1 (
      .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt), .ex_rs (ex_rs), .ex_rt (ex_rt),
      .ex_mem_read (ex_mem_read), .ex_rd (ex_rd), .stg_wr_en (stg_wr_en), .stg_rd (stg_rd),
      .mem_busy (mem_busy), .fwd_a_sel (aSel1), .fwd_b_sel (bSel1), .pc_hold (pc1),
      .ifid_hold (ifid1), .idex_flush (fl1), .pipe_freeze (fz1)
`ifdef FWD_HAZARD_STATS_EN
      , .stall_cnt (sc1), .freeze_cnt (fc1), .fwd_cnt (wc1)
`endif
   );

   fwd_hazard_unit #(.REG_AW(5), .NUM_FWD_STAGES(2), .LOAD_LAT(3)) u_dut3 (
      .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt), .ex_rs (ex_rs), .ex_rt (ex_rt),
      .ex_mem_read (ex_mem_read), .ex_rd (ex_rd), .stg_wr_en (stg_wr_en), .stg_rd (stg_rd),
      .mem_busy (mem_busy), .fwd_a_sel (aSel3), .fwd_b_sel (bSel3), .pc_hold (pc3),
      .ifid_hold (ifid3), .idex_flush (fl3), .pipe_freeze (fz3)
`ifdef FWD_HAZARD_STATS_EN
      , .stall_cnt (sc3), .freeze_cnt (fc3), .fwd_cnt (wc3)
`endif
   );

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic [3:0] c1;  // {pc_hold, ifid_hold, idex_flush, pipe_freeze} for LOAD_LAT=1
      logic [3:0] c3;  // same for LOAD_LAT=3
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: stall cycles still owed, and whether the previous cycle was frozen.
   int   rem[2];
   bit   prevBusy[2];

   function automatic logic [1:0] fwdModel(input logic [4:0] r, input logic [1:0] en,
                                           input logic [9:0] rd);
      for (int k = 0; k < 2; k++) begin
         if (r != 5'd0 && en[k] && rd[k*5 +: 5] == r) return 2'(k + 1);
      end
      return 2'd0;
   endfunction

   function automatic logic [3:0] ctlModel(input int idx, input int lat, input logic r,
                                           input logic busy, input logic hzV);
      if (r) begin
         rem[idx] = 0;
         prevBusy[idx] = 1'b0;
         return 4'b0000;
      end
      if (busy) begin
         prevBusy[idx] = 1'b1;
         return 4'b1101;
      end
      if (prevBusy[idx]) begin
         prevBusy[idx] = 1'b0;
         return 4'b0000;
      end
      if (rem[idx] > 0) begin
         rem[idx]--;
         return 4'b1110;
      end
      if (hzV) begin
         rem[idx] = lat - 1;
         return 4'b1110;
      end
      return 4'b0000;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
      end
   endtask

   // Drive one cycle of stimulus just after a rising edge and queue what the DUTs must show.
   task automatic step(input logic r, input logic busy, input logic mr, input logic [4:0] iRs,
                       input logic [4:0] iRt, input logic [4:0] eRs, input logic [4:0] eRt,
                       input logic [4:0] eRd, input logic [1:0] en, input logic [9:0] rd);
      exp_t e;
      logic hzV;
      rst = r; mem_busy = busy; ex_mem_read = mr;
      id_rs = iRs; id_rt = iRt; ex_rs = eRs; ex_rt = eRt; ex_rd = eRd;
      stg_wr_en = en; stg_rd = rd;
      hzV  = mr && eRd != 5'd0 && (eRd == iRs || eRd == iRt);
      e.a  = fwdModel(eRs, en, rd);
      e.b  = fwdModel(eRt, en, rd);
      e.c1 = ctlModel(0, 1, r, busy, hzV);
      e.c3 = ctlModel(1, 3, r, busy, hzV);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 2'b00, 10'd0);
   endtask

   // Monitor: outputs are combinational, so every cycle presents a response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sel_a_dut1", {6'd0, aSel1}, {6'd0, e.a});
            chk("sel_b_dut1", {6'd0, bSel1}, {6'd0, e.b});
            chk("sel_a_dut3", {6'd0, aSel3}, {6'd0, e.a});
            chk("sel_b_dut3", {6'd0, bSel3}, {6'd0, e.b});
            chk("ctl_dut1", {4'd0, pc1, ifid1, fl1, fz1}, {4'd0, e.c1});
            chk("ctl_dut3", {4'd0, pc3, ifid3, fl3, fz3}, {4'd0, e.c3});
         end
      end
   end

   initial begin
      int waitCnt;
      rst = 1'b1; mem_busy = 1'b0; ex_mem_read = 1'b0;
      id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
      stg_wr_en = '0; stg_rd = '0;
      @(posedge clk);
      #1;
      // Reset state.
      step(1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 10'd0);
      idle(1);
      // Forwarding priority.
      step(0, 0, 0, 5'd1, 5'd2, 5'd8, 5'd8, 5'd3, 2'b11, {5'd8, 5'd8});
      step(0, 0, 0, 5'd1, 5'd2, 5'd8, 5'd7, 5'd3, 2'b10, {5'd8, 5'd8});
      step(0, 0, 0, 5'd1, 5'd2, 5'd0, 5'd7, 5'd3, 2'b11, {5'd0, 5'd7});
      step(0, 0, 0, 5'd1, 5'd2, 5'd6, 5'd7, 5'd3, 2'b01, {5'd6, 5'd7});
      // Load-use hazard, bubble clears ex_mem_read afterwards.
      step(0, 0, 1, 5'd1, 5'd9, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      idle(4);
      // Load into r0 never stalls.
      step(0, 0, 1, 5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 2'b00, 10'd0);
      idle(1);
      // Freeze in the middle of a stall.
      step(1, 0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 10'd0);
      step(0, 0, 1, 5'd1, 5'd9, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      step(0, 1, 0, 5'd1, 5'd9, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      step(0, 1, 0, 5'd1, 5'd9, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      idle(4);
`ifdef FWD_HAZARD_STATS_EN
      chk("stall_cnt_dut3", sc3[7:0], 8'd3);
      chk("freeze_cnt_dut3", fc3[7:0], 8'd2);
      chk("stall_cnt_dut1", sc1[7:0], 8'd1);
      chk("freeze_cnt_dut1", fc1[7:0], 8'd2);
`endif
      // Async reset while LOAD_LAT=3 unit is in LU_STALL.
      step(0, 0, 1, 5'd9, 5'd1, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      step(1, 0, 0, 5'd9, 5'd1, 5'd3, 5'd4, 5'd9, 2'b00, 10'd0);
      idle(3);
      // Randomized traffic with a small register range so matches are frequent.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))});
      end
      idle(2);
      waitCnt = 0;
      while (q.size() > 0 && waitCnt < 10) begin
         @(posedge clk);
         waitCnt++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0 pending", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
